shared_net_resolver: RTL and testbench

SHARED_NET_RESOLVER -- requirements
Module: shared_net_resolver

---
 rtl/shared_net_resolver.sv | 130 +++++++++++++
 tb/tb_shared_net_resolver.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/shared_net_resolver.sv
// Registered multi-driver net resolver: exclusive wire, wired-OR, wired-AND or
// round-robin resolution, with a saturating contention counter for wire mode.
module shared_net_resolver #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int CNT_W = 8,
  localparam int OW   = (N > 2) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       drv_en,
  input  logic [N*WIDTH-1:0] drv_data,
  input  logic               clr_cnt,
  output logic [WIDTH-1:0]   net_out,
  output logic               net_valid,
  output logic               conflict,
  output logic [OW-1:0]      owner,
  output logic [CNT_W-1:0]   conflict_cnt
);

  logic [OW-1:0]    ptr, ptr_nxt;
  logic [OW-1:0]    low_idx, rr_idx, owner_nxt;
  logic [WIDTH-1:0] ref_data, or_val, and_val, rr_data, net_nxt;
  logic             any_en, mismatch, rr_found, valid_nxt, conflict_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  int               j;

  // NOTE: every signal gets a default before any branch so this block never infers a latch.
  always_comb begin
    any_en   = |drv_en;
    low_idx  = '0;
    ref_data = '0;
    or_val   = '0;
    and_val  = '1;
    mismatch = 1'b0;
    rr_found = 1'b0;
    rr_idx   = ptr;
    rr_data  = '0;
    j        = 0;

    // Only enabled drivers contribute, so data on disabled lanes is ignored.
    for (int i = N - 1; i >= 0; i--) begin
      if (drv_en[i]) begin
        low_idx  = OW'(i);
        ref_data = drv_data[i*WIDTH +: WIDTH];
      end
    end
    for (int i = 0; i < N; i++) begin
      if (drv_en[i]) begin
        or_val  = or_val | drv_data[i*WIDTH +: WIDTH];
        and_val = and_val & drv_data[i*WIDTH +: WIDTH];
        if (drv_data[i*WIDTH +: WIDTH] != ref_data) mismatch = 1'b1;
      end
    end

    // Round-robin search starts just after the last grant and wraps modulo N.
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!rr_found && drv_en[j]) begin
        rr_found = 1'b1;
        rr_idx   = OW'(j);
        rr_data  = drv_data[j*WIDTH +: WIDTH];
      end
    end

    net_nxt      = net_out;
    owner_nxt    = owner;
    valid_nxt    = 1'b0;
    conflict_nxt = 1'b0;
    ptr_nxt      = ptr;

    if (any_en) begin
      case (MODE)
        0: begin
          if (mismatch) begin
            conflict_nxt = 1'b1;
          end else begin
            net_nxt   = ref_data;
            owner_nxt = low_idx;
            valid_nxt = 1'b1;
          end
        end
        1: begin
          net_nxt   = or_val;
          owner_nxt = low_idx;
          valid_nxt = 1'b1;
        end
        2: begin
          net_nxt   = and_val;
          owner_nxt = low_idx;
          valid_nxt = 1'b1;
        end
        default: begin
          net_nxt   = rr_data;
          owner_nxt = rr_idx;
          valid_nxt = 1'b1;
          ptr_nxt   = rr_idx;
        end
      endcase
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    cnt_nxt = conflict_cnt;
    if (clr_cnt)
      cnt_nxt = '0;
    else if (conflict_nxt && (conflict_cnt != '1))
      cnt_nxt = conflict_cnt + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      net_out      <= '0;
      net_valid    <= 1'b0;
      conflict     <= 1'b0;
      owner        <= '0;
      conflict_cnt <= '0;
      ptr          <= OW'(N - 1);
    end else begin
      net_out      <= net_nxt;
      net_valid    <= valid_nxt;
      conflict     <= conflict_nxt;
      owner        <= owner_nxt;
      conflict_cnt <= cnt_nxt;
      ptr          <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_shared_net_resolver.sv
// Directed bench: five resolver instances (wire, OR, AND, round-robin, wire with
// a 2-bit counter) share one stimulus stream; expectations are hand-computed.
module tb_shared_net_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  drv_en;
  logic [31:0] drv_data;
  logic        clr_cnt;

  logic [7:0] net0, net1, net2, net3, net0c;
  logic       val0, val1, val2, val3, val0c;
  logic       cf0, cf1, cf2, cf3, cf0c;
  logic [1:0] own0, own1, own2, own3, own0c;
  logic [7:0] cnt0, cnt1, cnt2, cnt3;
  logic [1:0] cnt0c;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shared_net_resolver #(.WIDTH(8), .N(4), .MODE(0), .CNT_W(8)) u_m0 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
    .net_out(net0), .net_valid(val0), .conflict(cf0), .owner(own0), .conflict_cnt(cnt0));
  shared_net_resolver #(.WIDTH(8), .N(4), .MODE(1), .CNT_W(8)) u_m1 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
    .net_out(net1), .net_valid(val1), .conflict(cf1), .owner(own1), .conflict_cnt(cnt1));
  shared_net_resolver #(.WIDTH(8), .N(4), .MODE(2), .CNT_W(8)) u_m2 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
    .net_out(net2), .net_valid(val2), .conflict(cf2), .owner(own2), .conflict_cnt(cnt2));
  shared_net_resolver #(.WIDTH(8), .N(4), .MODE(3), .CNT_W(8)) u_m3 (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
    .net_out(net3), .net_valid(val3), .conflict(cf3), .owner(own3), .conflict_cnt(cnt3));
  shared_net_resolver #(.WIDTH(8), .N(4), .MODE(0), .CNT_W(2)) u_m0c (
    .clk(clk), .rst_n(rst_n), .drv_en(drv_en), .drv_data(drv_data), .clr_cnt(clr_cnt),
    .net_out(net0c), .net_valid(val0c), .conflict(cf0c), .owner(own0c), .conflict_cnt(cnt0c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag,
                           input logic [7:0] net, input logic v, input logic c,
                           input logic [1:0] o, input logic [7:0] cnt,
                           input logic [7:0] e_net, input logic e_v, input logic e_c,
                           input logic [1:0] e_o, input logic [7:0] e_cnt);
    check({tag, ".net"},   32'(net), 32'(e_net));
    check({tag, ".valid"}, 32'(v),   32'(e_v));
    check({tag, ".conf"},  32'(c),   32'(e_c));
    check({tag, ".owner"}, 32'(o),   32'(e_o));
    check({tag, ".cnt"},   32'(cnt), 32'(e_cnt));
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic step(input logic [3:0] en, input logic [7:0] d3, input logic [7:0] d2,
                      input logic [7:0] d1, input logic [7:0] d0, input logic clr);
    @(negedge clk);
    drv_en   = en;
    drv_data = {d3, d2, d1, d0};
    clr_cnt  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    drv_en   = '0;
    drv_data = '0;
    clr_cnt  = 1'b0;
    #12;
    check_all("rst_m0", net0, val0, cf0, own0, cnt0, 8'h00, 0, 0, 0, 8'd0);
    check_all("rst_m3", net3, val3, cf3, own3, cnt3, 8'h00, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single driver, disabled lanes carry junk.
    step(4'b0001, 8'h22, 8'h11, 8'hFF, 8'hA5, 0);
    check_all("s1_m0", net0, val0, cf0, own0, cnt0, 8'hA5, 1, 0, 0, 8'd0);
    check_all("s1_m1", net1, val1, cf1, own1, cnt1, 8'hA5, 1, 0, 0, 8'd0);
    check_all("s1_m2", net2, val2, cf2, own2, cnt2, 8'hA5, 1, 0, 0, 8'd0);
    check_all("s1_m3", net3, val3, cf3, own3, cnt3, 8'hA5, 1, 0, 0, 8'd0);

    // a=1 / b=0 contention.
    step(4'b0011, 8'h0F, 8'hF0, 8'h00, 8'h01, 0);
    check_all("s2_m0", net0, val0, cf0, own0, cnt0, 8'hA5, 0, 1, 0, 8'd1);
    check_all("s2_m1", net1, val1, cf1, own1, cnt1, 8'h01, 1, 0, 0, 8'd0);
    check_all("s2_m2", net2, val2, cf2, own2, cnt2, 8'h00, 1, 0, 0, 8'd0);
    check_all("s2_m3", net3, val3, cf3, own3, cnt3, 8'h00, 1, 0, 1, 8'd0);
    check("s2_m0c.cnt", 32'(cnt0c), 32'd1);

    // Identical data from two drivers resolves cleanly.
    step(4'b0101, 8'hAA, 8'h3C, 8'hFF, 8'h3C, 0);
    check_all("s3_m0", net0, val0, cf0, own0, cnt0, 8'h3C, 1, 0, 0, 8'd1);
    check_all("s3_m3", net3, val3, cf3, own3, cnt3, 8'h3C, 1, 0, 2, 8'd0);

    step(4'b1111, 8'h08, 8'h04, 8'h02, 8'h01, 0);
    check_all("s4_m0", net0, val0, cf0, own0, cnt0, 8'h3C, 0, 1, 0, 8'd2);
    check_all("s4_m1", net1, val1, cf1, own1, cnt1, 8'h0F, 1, 0, 0, 8'd0);
    check_all("s4_m2", net2, val2, cf2, own2, cnt2, 8'h00, 1, 0, 0, 8'd0);
    check_all("s4_m3", net3, val3, cf3, own3, cnt3, 8'h08, 1, 0, 3, 8'd0);

    // Idle: valid drops, net and owner hold.
    step(4'b0000, 8'h55, 8'h66, 8'h77, 8'h88, 0);
    check_all("s5_m0", net0, val0, cf0, own0, cnt0, 8'h3C, 0, 0, 0, 8'd2);
    check_all("s5_m1", net1, val1, cf1, own1, cnt1, 8'h0F, 0, 0, 0, 8'd0);
    check_all("s5_m3", net3, val3, cf3, own3, cnt3, 8'h08, 0, 0, 3, 8'd0);

    step(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    check("clr_m0.cnt", 32'(cnt0), 32'd0);
    check("clr_m0c.cnt", 32'(cnt0c), 32'd0);

    // Saturation on the 2-bit counter instance.
    for (int n = 1; n <= 5; n++) begin
      step(4'b0011, 8'h00, 8'h00, 8'h00, 8'h01, 0);
      check($sformatf("sat%0d_m0.cnt", n), 32'(cnt0), 32'(n));
      check($sformatf("sat%0d_m0c.cnt", n), 32'(cnt0c), (n < 3) ? 32'(n) : 32'd3);
      check($sformatf("sat%0d_m0c.net", n), 32'(net0c), 32'h3C);
    end

    step(4'b0011, 8'h00, 8'h00, 8'h00, 8'h01, 1);
    check_all("clrpri_m0", net0, val0, cf0, own0, cnt0, 8'h3C, 0, 1, 0, 8'd0);
    check("clrpri_m0c.cnt", 32'(cnt0c), 32'd0);
    check("clrpri_m1.cnt", 32'(cnt1), 32'd0);

    step(4'b0011, 8'h00, 8'h00, 8'h00, 8'h01, 0);
    check("pre_rst_m0.cnt", 32'(cnt0), 32'd1);

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    check_all("arst_m0", net0, val0, cf0, own0, cnt0, 8'h00, 0, 0, 0, 8'd0);
    check_all("arst_m1", net1, val1, cf1, own1, cnt1, 8'h00, 0, 0, 0, 8'd0);
    check_all("arst_m3", net3, val3, cf3, own3, cnt3, 8'h00, 0, 0, 0, 8'd0);
    check("arst_m0c.cnt", 32'(cnt0c), 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_m0.conf", 32'(cf0), 32'd0);

    // Release with round-robin traffic ready; nothing moves before the edge.
    @(negedge clk);
    rst_n    = 1'b1;
    drv_en   = 4'b1111;
    drv_data = {8'h40, 8'h30, 8'h20, 8'h10};
    clr_cnt  = 1'b0;
    #1;
    check_all("rel_m3", net3, val3, cf3, own3, cnt3, 8'h00, 0, 0, 0, 8'd0);
    @(posedge clk);
    #1;
    check_all("rr0_m3", net3, val3, cf3, own3, cnt3, 8'h10, 1, 0, 0, 8'd0);
    step(4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr1_m3", net3, val3, cf3, own3, cnt3, 8'h20, 1, 0, 1, 8'd0);
    step(4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr2_m3", net3, val3, cf3, own3, cnt3, 8'h30, 1, 0, 2, 8'd0);
    step(4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr3_m3", net3, val3, cf3, own3, cnt3, 8'h40, 1, 0, 3, 8'd0);
    step(4'b1111, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr4_m3", net3, val3, cf3, own3, cnt3, 8'h10, 1, 0, 0, 8'd0);
    step(4'b0000, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr_idle_m3", net3, val3, cf3, own3, cnt3, 8'h10, 0, 0, 0, 8'd0);
    step(4'b1010, 8'h40, 8'h30, 8'h20, 8'h10, 0);
    check_all("rr5_m3", net3, val3, cf3, own3, cnt3, 8'h20, 1, 0, 1, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
